// File: rtl/ice40_regs_ctrl_pkg.sv
// Shared definitions for the iCE40 register-file controller: default sizes,
// controller state encoding and the hard-wired zero register address.
package ice40_regs_ctrl_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/ice40_regs_fwd.sv
// Per-port read-data mux: zero register beats a forwarded write, which beats RAM data.
module ice40_regs_fwd
  import ice40_regs_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rdata
);

  logic is_zero;

  assign is_zero = (ZERO_REG != 0) && (rs == ADDR_W'(REG_ZERO));

  always_comb begin
    rdata = ram_rdata;
    if (is_zero) begin
      rdata = '0;
    end else if (wen && (waddr == rs)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/ice40_regs_ctrl.sv
// Controller for the 2R/1W iCE40 register-file RAM. With ICE40_REGS_CLEAR_EN
// defined the RAM is swept to zero after reset; otherwise RUN follows reset directly.
module ice40_regs_ctrl
  import ice40_regs_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              init_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr1,
  output logic [ADDR_W-1:0] ram_raddr2,
  input  logic [DATA_W-1:0] ram_rdata1,
  input  logic [DATA_W-1:0] ram_rdata2
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              rd_valid_reg;
  logic [ADDR_W-1:0] rs1_reg, rs2_reg;
  logic              wen_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              wr_ok;
  logic [DATA_W-1:0] fwd1, fwd2;

  // Writes to the zero register never reach the RAM or the forwarding path.
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= CLEAR;
      clr_cnt_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      wen_reg      <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= (state_reg == CLEAR) ? clr_cnt_reg + 1'b1 : '0;
      rd_valid_reg <= (state_reg == RUN) && rd_req;
      rs1_reg      <= rs1;
      rs2_reg      <= rs2;
      wen_reg      <= (state_reg == RUN) && wr_ok;
      waddr_reg    <= wr_addr;
      wdata_reg    <= wr_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    ram_wen    = 1'b0;
    ram_waddr  = wr_addr;
    ram_wdata  = wr_data;
    case (state_reg)
      CLEAR: begin
`ifdef ICE40_REGS_CLEAR_EN
        ram_wen   = 1'b1;
        ram_waddr = clr_cnt_reg;
        ram_wdata = '0;
        if (clr_cnt_reg == LAST_ADDR) begin
          state_next = RUN;
        end
`else
        state_next = RUN;
`endif
      end
      RUN: begin
        ram_wen = wr_ok;
      end
      default: state_next = CLEAR;
    endcase
  end

  assign init_done  = (state_reg == RUN);
  assign ram_raddr1 = rs1;
  assign ram_raddr2 = rs2;

  ice40_regs_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd1 (
    .rs(rs1_reg), .wen(wen_reg), .waddr(waddr_reg), .wdata(wdata_reg),
    .ram_rdata(ram_rdata1), .rdata(fwd1)
  );

  ice40_regs_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd2 (
    .rs(rs2_reg), .wen(wen_reg), .waddr(waddr_reg), .wdata(wdata_reg),
    .ram_rdata(ram_rdata2), .rdata(fwd2)
  );

  // Read data is masked to zero whenever it is not being presented as valid.
  assign rd_valid = rd_valid_reg;
  assign rdata1   = rd_valid_reg ? fwd1 : '0;
  assign rdata2   = rd_valid_reg ? fwd2 : '0;

endmodule

// File: doc/ice40_regs_ctrl.md
Name: ice40_regs_ctrl

Overview:
- Client-side controller that drives the 2-read/1-write iCE40 register-file RAM (64 x 32, registered reads) on behalf of the soft CPU core.
- After reset, sweeps the RAM clean.
- Presents a 1-cycle read request/valid interface with write-to-read forwarding and a hard-wired zero register.
- Sits between the CPU decode/writeback stages and the RAM register file.

Parameters:
ADDR_W, 6, register address width; depth = 2**ADDR_W
DATA_W, 32, register data width
ZERO_REG, 1, when 1 address 0 reads as 0 and writes to it are discarded

Ports:
clk  in  1  system clock, all logic rising-edge
resetn  in  1  synchronous active-low reset
init_done  out  1  high once RAM sweep complete; CPU must not issue requests while low
rd_req  in  1  read request for rs1/rs2 this cycle
rs1  in  ADDR_W  read address, port 1
rs2  in  ADDR_W  read address, port 2
rd_valid  out  1  rdata1/rdata2 valid (one cycle after accepted rd_req)
rdata1  out  DATA_W  read result, port 1
rdata2  out  DATA_W  read result, port 2
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
ram_wen  out  1  RAM write enable
ram_waddr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
ram_raddr1  out  ADDR_W  RAM read address 1
ram_raddr2  out  ADDR_W  RAM read address 2
ram_rdata1  in  DATA_W  RAM registered read data 1
ram_rdata2  in  DATA_W  RAM registered read data 2

Behaviour:
- States: CLEAR, RUN.
- resetn low at a clock edge:
  - state=CLEAR, clear counter=0, init_done=0, rd_valid=0, forwarding registers cleared.
  - rdata1/rdata2 read 0 while rd_valid=0 (outputs are masked, not raw RAM).
- CLEAR:
  - ram_wen=1, ram_waddr=counter, ram_wdata=0; counter increments each cycle.
  - After address 2**ADDR_W-1 is written (64 cycles), state moves to RUN and init_done=1 on the next cycle.
  - rd_req and wr_en are ignored in CLEAR; rd_valid stays 0.
- RUN:
  - ram_raddr1/2 are combinational copies of rs1/rs2.
  - ram_wen/ram_waddr/ram_wdata are combinational copies of wr_en/wr_addr/wr_data, except when ZERO_REG=1 and wr_addr=0, which forces ram_wen=0.
- Read latency is exactly 1: rd_req at edge N gives rd_valid=1 during cycle N+1 with data; with no rd_req, rd_valid=0 next cycle.
- Back-to-back rd_req every cycle is supported, with full throughput.
- Forwarding:
  - The controller registers (wr_en, wr_addr, wr_data) and (rs1, rs2) at each edge.
  - In cycle N+1, rdataK = registered wr_data if the registered wr_en=1 and the registered wr_addr equals the registered rsK (and the address is not 0 under ZERO_REG); otherwise ram_rdataK.
  - This covers a same-cycle write and read of one address, because RAM same-address behaviour is not relied upon.
- ZERO_REG=1: a registered rsK of 0 forces rdataK=0, overriding forwarding and RAM.
- Writes in cycle N+1 do not affect data returned for a request accepted at N, other than through the forwarding rule above.
- Reset asserted mid-CLEAR or mid-RUN restarts the sweep at address 0; any in-flight read is dropped (rd_valid=0).

Optional Feature:
- Macro ICE40_REGS_CLEAR_EN.
- Defined: CLEAR sweep as above.
- Undefined:
  - No CLEAR state; RUN is entered directly out of reset and init_done=1 in the first cycle after reset deasserts.
  - RAM contents are undefined until written; ZERO_REG masking still applies.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W defaults
  - state encoding (CLEAR=1'b0, RUN=1'b1)
  - zero-register constant REG_ZERO=0
- One sub-module, ice40_regs_fwd: per-port forwarding/zero mux taking the registered rs, registered write tuple and RAM data, producing rdata. It is instantiated twice.

Test Plan:
- Reset then idle: resetn low for 2 cycles, then high. With CLEAR_EN, expect ram_wen=1 for exactly 64 cycles at addresses 0..63 with data 0, then init_done=1. Without CLEAR_EN, expect init_done=1 on cycle 1.
- Simple write/read: write 0xDEADBEEF to 5; two cycles later rd_req rs1=5, rs2=0. Next cycle expect rd_valid=1, rdata1=0xDEADBEEF, rdata2=0.
- Same-cycle hazard: wr_en to 7 with 0x12345678 and rd_req rs1=7, rs2=7 in the same cycle. Next cycle expect both rdata=0x12345678, independent of the RAM model.
- Zero register: write 0xFFFFFFFF to 0, then read rs1=0. Expect ram_wen=0 on the write cycle and rdata1=0.
- Streaming: rd_req held high for 10 cycles over addresses 1..10 after writing value=addr*3. Expect rd_valid high for 10 consecutive cycles with the matching data.
- Reset mid-operation: assert resetn low at clear counter=30, release. Expect the sweep to restart at 0 and take the full 64 cycles. Also assert reset with a read in flight and expect rd_valid=0.
